// File: rtl/imm_ext_pipe_if.sv
// Request/response bundle for imm_ext_pipe: instruction-side push handshake
// and the extended-immediate queue head seen by the consumer.
interface imm_ext_pipe_if #(
  parameter int XLEN = 32
);
  logic [31:0]     inst;
  logic [2:0]      src;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ext;
  logic            err;
  logic [7:0]      err_cnt;

  modport master (
    output inst, src, in_valid, out_ready,
    input  in_ready, out_valid, ext, err, err_cnt
  );

  modport slave (
    input  inst, src, in_valid, out_ready,
    output in_ready, out_valid, ext, err, err_cnt
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// RISC-V immediate extractor feeding a small FIFO; each accepted instruction
// becomes one registered {ext, err} entry delivered in order to the consumer.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  imm_ext_pipe_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL      = DEPTH[AW:0];
  localparam logic [AW:0]   COUNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;

  logic [XLEN-1:0] ext_mem [DEPTH];
  logic            err_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      err_count;

  logic            push;
  logic            pop;
  logic [XLEN-1:0] imm;
  logic            ill;
  logic [5:0]      shamt;
  logic            is_shift;

  assign bus.in_ready  = (count < FULL);
  assign bus.out_valid = (count != '0);
  assign bus.ext       = ext_mem[rd_ptr];
  assign bus.err       = err_mem[rd_ptr];
  assign bus.err_cnt   = err_count;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Only OP-IMM shifts carry a shamt in the I slot; loads etc. keep the signed imm.
  assign is_shift = (bus.inst[6:0] == 7'b0010011) &&
                    ((bus.inst[14:12] == 3'b001) || (bus.inst[14:12] == 3'b101));
  assign shamt    = (XLEN == 64) ? bus.inst[25:20] : {1'b0, bus.inst[24:20]};

  always_comb begin
    imm = '0;
    ill = 1'b0;
    case (bus.src)
      3'b000: imm = is_shift ? XLEN'(shamt) : XLEN'($signed(bus.inst[31:20]));
      3'b001: imm = XLEN'($signed({bus.inst[31:25], bus.inst[11:7]}));
      3'b101: imm = XLEN'($signed({bus.inst[31], bus.inst[7], bus.inst[30:25],
                                   bus.inst[11:8], 1'b0}));
      3'b010: imm = XLEN'($signed({bus.inst[31:12], 12'b0}));
      3'b110: imm = XLEN'($signed({bus.inst[31], bus.inst[19:12], bus.inst[20],
                                   bus.inst[30:21], 1'b0}));
      3'b011: imm = XLEN'(bus.inst[19:15]);
      default: begin
        imm = '0;
        ill = 1'b1;
      end
    endcase
  end

  // Payload storage is never reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ext_mem[wr_ptr] <= imm;
      err_mem[wr_ptr] <= ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      if (push && ill && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: a 32-bit/DEPTH=4 and a 64-bit/DEPTH=2 instance share
// stimulus and are compared every cycle against an arithmetic queue model.
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.XLEN(32)) bus32 ();
  imm_ext_pipe_if #(.XLEN(64)) bus64 ();

  imm_ext_pipe #(.XLEN(32), .DEPTH(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  imm_ext_pipe #(.XLEN(64), .DEPTH(2)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

  typedef struct {
    logic [63:0] ext;
    logic        err;
  } entry_t;

  entry_t q32[$];
  entry_t q64[$];
  int     ec32 = 0;
  int     ec64 = 0;
  int     checks = 0;
  int     errors = 0;
  bit     armed = 1'b0;

  // Immediates rebuilt from field weights; the sign bit contributes a negative power of two.
  function automatic logic [63:0] refImm(input logic [31:0] i, input logic [2:0] s,
                                         input int xlen, output logic e);
    longint v;
    v = 0;
    e = 1'b0;
    case (s)
      3'b000: begin
        if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5))
          v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
        else begin
          v = longint'(i[30:20]);
          if (i[31]) v -= 2048;
        end
      end
      3'b001: begin
        v = longint'(i[30:25]) * 32 + longint'(i[11:7]);
        if (i[31]) v -= 2048;
      end
      3'b101: begin
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (i[31]) v -= 4096;
      end
      3'b010: begin
        v = longint'(i[30:12]) * 4096;
        if (i[31]) v -= 64'sd2147483648;
      end
      3'b110: begin
        v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (i[31]) v -= 64'sd1048576;
      end
      3'b011: v = longint'(i[19:15]);
      default: begin
        v = 0;
        e = 1'b1;
      end
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic checkSide(input string tag, input int depth, input entry_t q[$], input int ec,
                           input logic in_ready, input logic out_valid, input logic [63:0] ext,
                           input logic err, input logic [7:0] err_cnt);
    checkOutput({tag, "_in_ready"}, in_ready, q.size() < depth);
    checkOutput({tag, "_out_valid"}, out_valid, q.size() > 0);
    checkOutput({tag, "_err_cnt"}, err_cnt, ec);
    if (q.size() > 0) begin
      checkOutput({tag, "_ext"}, ext, q[0].ext);
      checkOutput({tag, "_err"}, err, q[0].err);
    end
  endtask

  // Drive one cycle: check at the falling edge, update the model at the rising edge.
  task automatic applyStimulus(input logic r, input logic [31:0] i, input logic [2:0] s,
                               input logic v, input logic ordy);
    bit     p32, p64, o32, o64;
    entry_t e;
    logic   er;
    rst = r;
    bus32.inst = i; bus32.src = s; bus32.in_valid = v; bus32.out_ready = ordy;
    bus64.inst = i; bus64.src = s; bus64.in_valid = v; bus64.out_ready = ordy;
    @(negedge clk);
    if (armed) begin
      checkSide("d32", 4, q32, ec32, bus32.in_ready, bus32.out_valid, {32'b0, bus32.ext},
                bus32.err, bus32.err_cnt);
      checkSide("d64", 2, q64, ec64, bus64.in_ready, bus64.out_valid, bus64.ext,
                bus64.err, bus64.err_cnt);
    end
    p32 = v && (q32.size() < 4);
    o32 = ordy && (q32.size() > 0);
    p64 = v && (q64.size() < 2);
    o64 = ordy && (q64.size() > 0);
    @(posedge clk);
    if (r) begin
      q32.delete();
      q64.delete();
      ec32 = 0;
      ec64 = 0;
      armed = 1'b1;
    end else begin
      if (o32) void'(q32.pop_front());
      if (p32) begin
        e.ext = refImm(i, s, 32, er);
        e.err = er;
        q32.push_back(e);
        if (er && ec32 < 255) ec32++;
      end
      if (o64) void'(q64.pop_front());
      if (p64) begin
        e.ext = refImm(i, s, 64, er);
        e.err = er;
        q64.push_back(e);
        if (er && ec64 < 255) ec64++;
      end
    end
    #1;
  endtask

  logic [31:0] ri;
  logic [2:0]  rs;
  int          seen;

  initial begin
    rst = 1'b1;
    bus32.inst = '0; bus32.src = '0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus64.inst = '0; bus64.src = '0; bus64.in_valid = 1'b0; bus64.out_ready = 1'b0;
    applyStimulus(1, 32'h0, 3'b000, 0, 0);
    applyStimulus(1, 32'h0, 3'b000, 1, 1);
    checkOutput("rst_in_ready", bus32.in_ready, 1'b1);
    checkOutput("rst_out_valid", bus32.out_valid, 1'b0);
    checkOutput("rst_err_cnt", bus32.err_cnt, 8'd0);

    applyStimulus(0, 32'hFFF00093, 3'b000, 1, 0);
    checkOutput("addi_valid", bus32.out_valid, 1'b1);
    checkOutput("addi_ext32", {32'b0, bus32.ext}, 64'hFFFF_FFFF);
    checkOutput("addi_err", bus32.err, 1'b0);
    applyStimulus(0, 32'h0, 3'b000, 0, 1);

    applyStimulus(0, 32'h4030D093, 3'b000, 1, 1);
    checkOutput("srai_ext32", {32'b0, bus32.ext}, 64'h3);
    checkOutput("srai_ext64", bus64.ext, 64'h3);
    applyStimulus(0, 32'hFFF05083, 3'b000, 1, 1);
    checkOutput("lhu_ext32", {32'b0, bus32.ext}, 64'hFFFF_FFFF);
    checkOutput("lhu_ext64", bus64.ext, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(0, 32'h0, 3'b000, 0, 1);

    applyStimulus(0, 32'hFE000EE3, 3'b101, 1, 1);
    checkOutput("br_ext64", bus64.ext, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("br_ext32", {32'b0, bus32.ext}, 64'hFFFF_FFFC);
    applyStimulus(0, 32'h0, 3'b000, 0, 1);

    for (int k = 1; k <= 5; k++) begin
      applyStimulus(0, {12'(k), 20'h00093}, 3'b000, 1, 0);
      if (k == 4) checkOutput("full_in_ready", bus32.in_ready, 1'b0);
    end
    for (int k = 1; k <= 4; k++) begin
      checkOutput("order_ext", {32'b0, bus32.ext}, 64'(k));
      applyStimulus(0, 32'h0, 3'b000, 0, 1);
    end
    checkOutput("drained", bus32.out_valid, 1'b0);

    applyStimulus(0, 32'h00700093, 3'b000, 1, 0);
    applyStimulus(0, 32'h00800093, 3'b000, 1, 0);
    applyStimulus(0, 32'h00900093, 3'b000, 1, 1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus32.out_valid) seen++;
      applyStimulus(0, 32'h0, 3'b000, 0, 1);
    end
    checkOutput("occ_keep", seen, 2);

    for (int k = 0; k < 300; k++) applyStimulus(0, $urandom, 3'b100, 1, 1);
    applyStimulus(0, 32'h0, 3'b000, 0, 1);
    checkOutput("sat_cnt32", bus32.err_cnt, 8'd255);
    checkOutput("sat_cnt64", bus64.err_cnt, 8'd255);

    for (int k = 0; k < 3; k++) applyStimulus(0, 32'h00100093, 3'b000, 1, 0);
    applyStimulus(1, 32'h00200093, 3'b100, 1, 1);
    checkOutput("mid_rst_valid", bus32.out_valid, 1'b0);
    checkOutput("mid_rst_ready", bus32.in_ready, 1'b1);
    checkOutput("mid_rst_cnt", bus32.err_cnt, 8'd0);
    applyStimulus(0, 32'h00500093, 3'b000, 1, 0);
    checkOutput("post_rst_ext", {32'b0, bus32.ext}, 64'h5);
    applyStimulus(0, 32'h0, 3'b000, 0, 1);
    checkOutput("post_rst_alone", bus32.out_valid, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      ri = $urandom;
      rs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        ri[6:0]   = 7'h13;
        ri[14:12] = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b101;
        rs        = 3'b000;
      end
      applyStimulus(1'($urandom_range(0, 99) == 0), ri, rs,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving output immediate width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, giving output queue entries; legal values are powers of two, >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port inst, input, 32 bits: full instruction word.
REQ-006 SHALL have port src, input, 3 bits: format select; 000 I, 001 S, 101 B, 010 U, 110 J, 011 CSR-zimm; 100 and 111 are illegal.
REQ-007 SHALL have port in_valid, input, 1 bit: inst/src are valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes head this cycle.
REQ-011 SHALL have port ext, output, XLEN bits: extended immediate of head entry.
REQ-012 SHALL have port err, output, 1 bit: head entry was built from an illegal src.
REQ-013 SHALL have port err_cnt, output, 8 bits: saturating count of accepted illegal-src requests.

Function
REQ-014 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1 ("push").
REQ-015 SHALL retire the head on a rising edge where out_valid=1 and out_ready=1 ("pop").
REQ-016 SHALL drive in_ready = (occupancy < DEPTH); no pass-through when full, so a full queue with a simultaneous pop still refuses the push that cycle.
REQ-017 SHALL drive out_valid = (occupancy > 0); ext/err SHALL come from registered queue storage, not from inst.
REQ-018 SHALL give 1-cycle latency: a request pushed into an empty queue at edge N is presented with out_valid=1 after edge N.
REQ-019 SHALL, on simultaneous push and pop with 0 < occupancy < DEPTH, keep occupancy unchanged and preserve FIFO order.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; occupancy counter range is 0..DEPTH.
REQ-021 SHALL hold ext/err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL compute the I format as sign-extend(inst[31:20]).
REQ-023 SHALL compute the I format as a shift amount instead when inst[6:0]=0010011 and inst[14:12] is 001 or 101: zero-extend inst[24:20] for XLEN=32, inst[25:20] for XLEN=64; other opcodes with funct3 001/101 (e.g. loads) SHALL use REQ-022.
REQ-024 SHALL compute the S format as sign-extend({inst[31:25], inst[11:7]}).
REQ-025 SHALL compute the B format as sign-extend({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
REQ-026 SHALL compute the U format as sign-extend({inst[31:12], 12'b0}) to XLEN.
REQ-027 SHALL compute the J format as sign-extend({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
REQ-028 SHALL compute the CSR-zimm format as zero-extend(inst[19:15]).
REQ-029 SHALL, for illegal src, store ext=0 and err=1; all legal formats store err=0.
REQ-030 SHALL increment err_cnt once per pushed illegal request, saturating at 255; no wrap.
REQ-031 SHALL ignore inst/src when no push occurs.

Reset
REQ-032 SHALL, while rst=1 at an edge, clear occupancy and pointers, set err_cnt=0, and drive out_valid=0 and in_ready=1 from the next cycle.
REQ-033 SHALL discard all queued entries when rst asserts mid-operation; pushes and pops in the reset cycle have no effect.
REQ-034 SHALL not reset queue storage data; ext/err are don't-care while out_valid=0.

Verification
REQ-035 SHALL be verified with: XLEN=32, inst=0xFFF00093, src=000 pushed to empty queue -> next cycle out_valid=1, ext=0xFFFFFFFF, err=0.
REQ-036 SHALL be verified with: inst=0x4030D093 (SRAI, shamt 3), src=000 -> ext=0x00000003; then inst=0xFFF05083 (LHU), src=000 -> ext=0xFFFFFFFF.
REQ-037 SHALL be verified with: XLEN=64, inst=0xFE000EE3, src=101 -> ext=0xFFFFFFFFFFFFFFFC; same inst with XLEN=32 -> 0xFFFFFFFC.
REQ-038 SHALL be verified with: DEPTH=4, out_ready=0, 5 back-to-back pushes -> in_ready=0 after the 4th, 5th not accepted; then out_ready=1 -> 4 entries out in push order; simultaneous push/pop at occupancy 2 -> occupancy stays 2.
REQ-039 SHALL be verified with: 300 pushes with src=100 -> each output ext=0, err=1; err_cnt stops at 255.
REQ-040 SHALL be verified with: 3 entries queued, then rst=1 for one cycle -> next cycle out_valid=0, in_ready=1, err_cnt=0; a new push then appears alone.
